// File: rtl/upc_perf_pkg.sv
// Shared types, read-select codes and status-word layout for the UPC performance monitor.
package upc_perf_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      HOLD = 2'd2
   } ch_state_t;

   localparam logic [2:0] RD_TXN    = 3'd0;
   localparam logic [2:0] RD_BUSY   = 3'd1;
   localparam logic [2:0] RD_MIN    = 3'd2;
   localparam logic [2:0] RD_MAX    = 3'd3;
   localparam logic [2:0] RD_ITER   = 3'd4;
   localparam logic [2:0] RD_STALL  = 3'd5;
   localparam logic [2:0] RD_STATUS = 3'd6;

   // Status word: state occupies bits [1:0], flags sit above it.
   localparam int ST_ERR    = 2;
   localparam int ST_OVF    = 3;
   localparam int ST_INC    = 4;
   localparam int ST_FROZEN = 5;

   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/upc_perf_monitor_if.sv
// Observation and read-port bundle between monitored HLS blocks and the performance monitor.
interface upc_perf_monitor_if
   import upc_perf_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 32
);
   localparam int CH_W = ch_width(NUM_CH);

   logic [NUM_CH-1:0] ch_start;
   logic [NUM_CH-1:0] ch_done;
   logic [NUM_CH-1:0] ch_continue;
   logic [NUM_CH-1:0] iter_start;
   logic [NUM_CH-1:0] stall;
   logic              finish;
   logic              clear;
   logic              rd_en;
   logic [CH_W-1:0]   rd_ch;
   logic [2:0]        rd_sel;
   logic              rd_valid;
   logic [CNT_W-1:0]  rd_data;

   modport master (
      output ch_start, ch_done, ch_continue, iter_start, stall,
      output finish, clear, rd_en, rd_ch, rd_sel,
      input  rd_valid, rd_data
   );

   modport slave (
      input  ch_start, ch_done, ch_continue, iter_start, stall,
      input  finish, clear, rd_en, rd_ch, rd_sel,
      output rd_valid, rd_data
   );

endinterface

// File: rtl/upc_perf_channel.sv
// One monitored channel: start/done/continue FSM, latency counter, statistics and sticky flags.
module upc_perf_channel
   import upc_perf_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int LAT_W = 24
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             hold_i,
   input  logic             start_i,
   input  logic             done_i,
   input  logic             cont_i,
   input  logic             iter_i,
   input  logic             stall_i,
   output logic [CNT_W-1:0] txn_o,
   output logic [CNT_W-1:0] busy_o,
   output logic [CNT_W-1:0] iter_o,
   output logic [CNT_W-1:0] stall_o,
   output logic [LAT_W-1:0] min_o,
   output logic [LAT_W-1:0] max_o,
   output ch_state_t        state_o,
   output logic             err_o,
   output logic             ovf_o,
   output logic             inc_o
);

   ch_state_t        state_q, state_d;
   logic [LAT_W-1:0] lat_q, lat_d, min_q, min_d, max_q, max_d, lat_cur;
   logic [CNT_W-1:0] txn_q, txn_d, busy_q, busy_d, iter_q, iter_d, stall_q, stall_d;
   logic             err_q, err_d, ovf_q, ovf_d, inc_q, inc_d, act;
   logic [CNT_W:0]   t;

   // MSB of the result flags that the counter was already pinned at all-ones.
   function automatic logic [CNT_W:0] cnt_inc(input logic [CNT_W-1:0] v);
      return (&v) ? {1'b1, v} : {1'b0, v + CNT_W'(1)};
   endfunction

   always_ff @(posedge clock) begin
      if (reset || clear_i) begin
         state_q <= IDLE;
         lat_q   <= '0;
         txn_q   <= '0;
         busy_q  <= '0;
         iter_q  <= '0;
         stall_q <= '0;
         min_q   <= '1;
         max_q   <= '0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         inc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         txn_q   <= txn_d;
         busy_q  <= busy_d;
         iter_q  <= iter_d;
         stall_q <= stall_d;
         min_q   <= min_d;
         max_q   <= max_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
         inc_q   <= inc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      txn_d   = txn_q;
      busy_d  = busy_q;
      iter_d  = iter_q;
      stall_d = stall_q;
      min_d   = min_q;
      max_d   = max_q;
      err_d   = err_q;
      ovf_d   = ovf_q;
      inc_d   = inc_q;
      t       = '0;
      act     = 1'b0;
      lat_cur = lat_q;
      if (hold_i) begin
         if (state_q != IDLE) inc_d = 1'b1;
      end else begin
         // A cycle that accepts a start counts as the first busy cycle of the transaction.
         act     = (state_q == BUSY) ||
                   (start_i && ((state_q == IDLE) || ((state_q == HOLD) && cont_i)));
         lat_cur = (state_q == BUSY) ? lat_q : LAT_W'(1);
         if (act || (state_q == HOLD)) begin
            t = cnt_inc(busy_q);  busy_d = t[CNT_W-1:0];  ovf_d = ovf_d | t[CNT_W];
         end
         if (act && iter_i) begin
            t = cnt_inc(iter_q);  iter_d = t[CNT_W-1:0];  ovf_d = ovf_d | t[CNT_W];
         end
         if (act && stall_i) begin
            t = cnt_inc(stall_q); stall_d = t[CNT_W-1:0]; ovf_d = ovf_d | t[CNT_W];
         end
         if (done_i && !act) err_d = 1'b1;
         if (act) begin
            if (done_i) begin
               t = cnt_inc(txn_q);   txn_d = t[CNT_W-1:0];   ovf_d = ovf_d | t[CNT_W];
               if (lat_cur < min_q) min_d = lat_cur;
               if (lat_cur > max_q) max_d = lat_cur;
               lat_d = LAT_W'(1);
               if (!cont_i)      state_d = HOLD;
               else if (start_i) state_d = BUSY;
               else              state_d = IDLE;
            end else begin
               state_d = BUSY;
               if (&lat_cur) ovf_d = 1'b1;
               else          lat_d = lat_cur + LAT_W'(1);
            end
         end else if ((state_q == HOLD) && cont_i) begin
            state_d = IDLE;
         end
      end
   end

   assign txn_o   = txn_q;
   assign busy_o  = busy_q;
   assign iter_o  = iter_q;
   assign stall_o = stall_q;
   assign min_o   = min_q;
   assign max_o   = max_q;
   assign state_o = state_q;
   assign err_o   = err_q;
   assign ovf_o   = ovf_q;
   assign inc_o   = inc_q;

endmodule

// File: rtl/upc_perf_monitor.sv
// Multi-channel HLS performance monitor: per-channel statistics, global freeze and a registered read port.
module upc_perf_monitor
   import upc_perf_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 32,
   parameter int LAT_W  = 24
) (
   input logic               clock,
   input logic               reset,
   upc_perf_monitor_if.slave bus
);

   localparam int CH_W = ch_width(NUM_CH);
   localparam int WW0  = (CNT_W > LAT_W) ? CNT_W : LAT_W;
   localparam int WW   = (WW0 > 8) ? WW0 : 8;

   logic             frozen_q, frozen_d, hold;
   logic             rd_valid_q, rd_valid_d;
   logic [CNT_W-1:0] rd_data_q, rd_data_d;
   logic [WW-1:0]    mux;
   logic [7:0]       s;

   logic [CNT_W-1:0] txn_a [NUM_CH];
   logic [CNT_W-1:0] busy_a [NUM_CH];
   logic [CNT_W-1:0] iter_a [NUM_CH];
   logic [CNT_W-1:0] stall_a [NUM_CH];
   logic [LAT_W-1:0] min_a [NUM_CH];
   logic [LAT_W-1:0] max_a [NUM_CH];
   ch_state_t        st_a [NUM_CH];
   logic [NUM_CH-1:0] err_a, ovf_a, inc_a;

   // Clear outranks finish; a finish still high afterwards freezes on the next edge.
   assign frozen_d = frozen_q | bus.finish;
   assign hold     = (bus.finish | frozen_q) & ~bus.clear;

   always_ff @(posedge clock) begin
      if (reset || bus.clear) frozen_q <= 1'b0;
      else                    frozen_q <= frozen_d;
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      upc_perf_channel #(.CNT_W(CNT_W), .LAT_W(LAT_W)) u_ch (
         .clock   (clock),
         .reset   (reset),
         .clear_i (bus.clear),
         .hold_i  (hold),
         .start_i (bus.ch_start[g]),
         .done_i  (bus.ch_done[g]),
         .cont_i  (bus.ch_continue[g]),
         .iter_i  (bus.iter_start[g]),
         .stall_i (bus.stall[g]),
         .txn_o   (txn_a[g]),
         .busy_o  (busy_a[g]),
         .iter_o  (iter_a[g]),
         .stall_o (stall_a[g]),
         .min_o   (min_a[g]),
         .max_o   (max_a[g]),
         .state_o (st_a[g]),
         .err_o   (err_a[g]),
         .ovf_o   (ovf_a[g]),
         .inc_o   (inc_a[g])
      );
   end

   always_comb begin
      mux = '0;
      s   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (bus.rd_ch == CH_W'(c)) begin
            case (bus.rd_sel)
               RD_TXN:    mux = WW'(txn_a[c]);
               RD_BUSY:   mux = WW'(busy_a[c]);
               RD_MIN:    mux = WW'(min_a[c]);
               RD_MAX:    mux = WW'(max_a[c]);
               RD_ITER:   mux = WW'(iter_a[c]);
               RD_STALL:  mux = WW'(stall_a[c]);
               RD_STATUS: begin
                  s[1:0]       = st_a[c];
                  s[ST_ERR]    = err_a[c];
                  s[ST_OVF]    = ovf_a[c];
                  s[ST_INC]    = inc_a[c];
                  s[ST_FROZEN] = frozen_q;
                  mux          = WW'(s);
               end
               default:   mux = '0;
            endcase
         end
      end
      rd_valid_d = bus.rd_en;
      rd_data_d  = bus.rd_en ? mux[CNT_W-1:0] : rd_data_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;

endmodule
